// File: rtl/bus_interrupt_controller.sv
// Memory-mapped interrupt controller for the 8-bit processor bus.
// It collects up to 8 synchronised interrupt sources, each with its own enable bit and
// edge/level mode. Fixed priority picks the lowest eligible index, and a raise/ack FSM
// presents that index to the processor.
//
// Handshake: int_raise is held high with int_id stable until int_ack is seen for one
// cycle. A mandatory one-cycle low (GAP) always follows before the next request;
// int_ack outside RAISED is ignored.
module bus_interrupt_controller #(
  parameter int          NUM_SOURCES = 4,
  parameter logic [7:0]  BASE_ADDR   = 8'hF0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  inout  wire  [7:0]             bus_data,
  input  logic [7:0]             bus_addr,
  input  logic                   bus_we,
  input  logic [NUM_SOURCES-1:0] irq_in,
  output logic                   int_raise,
  input  logic                   int_ack,
  output logic [2:0]             int_id,
  output logic [1:0]             fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RAISED = 2'd1, GAP = 2'd2} state_t;

  localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SOURCES) - 9'd1);

  state_t                 state;
  logic [NUM_SOURCES-1:0] enable;
  logic [NUM_SOURCES-1:0] mode;
  logic [NUM_SOURCES-1:0] pending;
  logic [NUM_SOURCES-1:0] sync1;
  logic [NUM_SOURCES-1:0] sync2;
  logic [NUM_SOURCES-1:0] prev;
  logic [NUM_SOURCES-1:0] pend_next;
  logic [NUM_SOURCES-1:0] eligible;
  logic [NUM_SOURCES-1:0] w1c;
  logic [NUM_SOURCES-1:0] ack_clr;
  logic [NUM_SOURCES-1:0] wr_val;
  logic [2:0]             winner;
  logic                   ack_fire;
  logic                   sel_en, sel_mode, sel_pend, sel_stat, sel_any;
  logic [7:0]             rd_val;
  logic [7:0]             rd_data;
  logic                   rd_oe;
  logic                   unused_bus;

  assign sel_en   = (bus_addr == BASE_ADDR);
  assign sel_mode = (bus_addr == BASE_ADDR + 8'd1);
  assign sel_pend = (bus_addr == BASE_ADDR + 8'd2);
  assign sel_stat = (bus_addr == BASE_ADDR + 8'd3);
  assign sel_any  = sel_en | sel_mode | sel_pend | sel_stat;

  // Bits above the implemented sources are accepted on writes and dropped.
  assign wr_val     = bus_data[NUM_SOURCES-1:0];
  assign unused_bus = ^(bus_data & ~SRC_MASK);

  assign bus_data  = rd_oe ? rd_data : 8'bz;
  assign fsm_state = state;
  assign eligible  = pending & enable;
  assign ack_fire  = (state == RAISED) && int_ack;

  // Next pending value: edge bits latch rises (a new rise beats a same-cycle clear), level bits follow sync.
  always_comb begin
    w1c       = (bus_we && sel_pend) ? wr_val : '0;
    ack_clr   = '0;
    pend_next = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      ack_clr[i]   = ack_fire && (int_id == 3'(i)) && !mode[i];
      pend_next[i] = mode[i] ? sync2[i]
                             : ((pending[i] & ~w1c[i] & ~ack_clr[i]) | (sync2[i] & ~prev[i]));
    end
  end

  // Fixed priority: scan high to low so the lowest eligible index is the last to assign.
  always_comb begin
    winner = 3'd0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  // Register read mux; unimplemented upper bits read as zero.
  always_comb begin
    rd_val = 8'h00;
    if (sel_en)        rd_val = 8'(enable);
    else if (sel_mode) rd_val = 8'(mode);
    else if (sel_pend) rd_val = 8'(pending);
    else if (sel_stat) rd_val = {int_raise, 4'b0000, int_id};
  end

  // Input synchronisers, edge history and the pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      pending <= '0;
    end else begin
      sync1   <= irq_in;
      sync2   <= sync1;
      prev    <= sync2;
      pending <= pend_next;
    end
  end

  // Writable configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable <= '0;
      mode   <= '0;
    end else if (bus_we) begin
      if (sel_en)   enable <= wr_val;
      if (sel_mode) mode   <= wr_val;
    end
  end

  // Read port: drive the bus for as long as a read of our address is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_oe   <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      rd_oe   <= sel_any && !bus_we;
      rd_data <= rd_val;
    end
  end

  // Raise/ack FSM with registered int_raise and int_id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      int_raise <= 1'b0;
      int_id    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            int_id    <= winner;
            int_raise <= 1'b1;
            state     <= RAISED;
          end
        end
        RAISED: begin
          if (int_ack) begin
            int_raise <= 1'b0;
            state     <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          int_raise <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_interrupt_controller.sv
// Directed bench for bus_interrupt_controller (NUM_SOURCES=4, BASE_ADDR=8'hF0).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_bus_interrupt_controller;

  localparam logic [7:0] BASE = 8'hF0;

  logic       clk;
  logic       rst_n;
  wire  [7:0] bus_data;
  logic [7:0] bus_addr;
  logic       bus_we;
  logic [3:0] irq_in;
  logic       int_raise;
  logic       int_ack;
  logic [2:0] int_id;
  logic [1:0] fsm_state;

  logic [7:0] drv_data;
  logic       drv_oe;
  assign bus_data = drv_oe ? drv_data : 8'bz;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  bus_interrupt_controller #(.NUM_SOURCES(4), .BASE_ADDR(8'hF0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_data  (bus_data),
    .bus_addr  (bus_addr),
    .bus_we    (bus_we),
    .irq_in    (irq_in),
    .int_raise (int_raise),
    .int_ack   (int_ack),
    .int_id    (int_id),
    .fsm_state (fsm_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  // One rising edge, returning at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    bus_addr = addr;
    bus_we   = 1'b1;
    drv_data = data;
    drv_oe   = 1'b1;
    step();
    bus_we   = 1'b0;
    drv_oe   = 1'b0;
    bus_addr = 8'h00;
  endtask

  // Pops the expected value from the scoreboard queue and compares the read data.
  task automatic read_chk(input string tag, input logic [7:0] addr);
    logic [7:0] got;
    logic [7:0] exp;
    bus_addr = addr;
    bus_we   = 1'b0;
    step();
    got      = bus_data;
    bus_addr = 8'h00;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty got=%02h", tag, got);
    end else begin
      exp = exp_q.pop_front();
      check(tag, got, exp);
    end
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n    = 1'b0;
    bus_addr = 8'h00;
    bus_we   = 1'b0;
    drv_data = 8'h00;
    drv_oe   = 1'b0;
    irq_in   = 4'hF;
    int_ack  = 1'b0;

    // Reset with all requests high
    steps(3);
    check("rst_raise", {7'd0, int_raise}, 8'h00);
    check("rst_id", {5'd0, int_id}, 8'h00);
    check("rst_state", {6'd0, fsm_state}, 8'h00);
    irq_in = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int a = 0; a < 4; a++) begin
      exp_q.push_back(8'h00);
      read_chk($sformatf("rst_reg%0d", a), BASE + 8'(a));
    end

    // Edge priority: sources 1 and 2 together, 1 wins first
    bus_write(BASE + 8'd0, 8'h0F);
    bus_write(BASE + 8'd1, 8'h00);
    irq_in = 4'b0110;
    step();
    irq_in = 4'b0000;
    steps(2);
    check("prio_e3_raise", {7'd0, int_raise}, 8'h00);
    step();
    check("prio_e4_raise", {7'd0, int_raise}, 8'h01);
    check("prio_e4_id", {5'd0, int_id}, 8'h01);
    ack_pulse();
    check("prio_gap_raise", {7'd0, int_raise}, 8'h00);
    check("prio_gap_state", {6'd0, fsm_state}, 8'h02);
    step();
    check("prio_idle_raise", {7'd0, int_raise}, 8'h00);
    step();
    check("prio_2nd_raise", {7'd0, int_raise}, 8'h01);
    check("prio_2nd_id", {5'd0, int_id}, 8'h02);
    exp_q.push_back(8'h04);
    read_chk("prio_pend_04", BASE + 8'd2);
    ack_pulse();
    exp_q.push_back(8'h00);
    read_chk("prio_pend_00", BASE + 8'd2);
    steps(2);
    check("prio_quiet", {7'd0, int_raise}, 8'h00);

    // Level re-raise on source 0
    bus_write(BASE + 8'd1, 8'h01);
    bus_write(BASE + 8'd0, 8'h01);
    irq_in = 4'b0001;
    steps(3);
    check("lvl_e3_raise", {7'd0, int_raise}, 8'h00);
    step();
    check("lvl_raise", {7'd0, int_raise}, 8'h01);
    check("lvl_id", {5'd0, int_id}, 8'h00);
    ack_pulse();
    check("lvl_low1", {7'd0, int_raise}, 8'h00);
    step();
    check("lvl_low2", {7'd0, int_raise}, 8'h00);
    step();
    check("lvl_reraise", {7'd0, int_raise}, 8'h01);
    check("lvl_reraise_id", {5'd0, int_id}, 8'h00);
    bus_write(BASE + 8'd2, 8'h01);
    exp_q.push_back(8'h01);
    read_chk("lvl_w1c_noeffect", BASE + 8'd2);
    irq_in = 4'b0000;
    steps(4);
    ack_pulse();
    steps(3);
    check("lvl_released", {7'd0, int_raise}, 8'h00);
    bus_write(BASE + 8'd1, 8'h00);
    bus_write(BASE + 8'd0, 8'h00);

    // Mask: pending without enable, then enable late
    irq_in = 4'b1000;
    step();
    irq_in = 4'b0000;
    steps(4);
    check("mask_no_raise", {7'd0, int_raise}, 8'h00);
    exp_q.push_back(8'h08);
    read_chk("mask_pend", BASE + 8'd2);
    ack_pulse();
    exp_q.push_back(8'h08);
    read_chk("idle_ack_ignored", BASE + 8'd2);
    bus_write(BASE + 8'd0, 8'h08);
    check("mask_wr_edge", {7'd0, int_raise}, 8'h00);
    step();
    check("mask_raise", {7'd0, int_raise}, 8'h01);
    check("mask_id", {5'd0, int_id}, 8'h03);
    exp_q.push_back(8'h83);
    read_chk("mask_status", BASE + 8'd3);
    ack_pulse();
    steps(3);
    check("mask_done", {7'd0, int_raise}, 8'h00);
    bus_write(BASE + 8'd0, 8'h00);

    // Disable while raised: request completes, no re-raise
    bus_write(BASE + 8'd0, 8'h02);
    irq_in = 4'b0010;
    step();
    irq_in = 4'b0000;
    steps(3);
    check("dis_raise", {7'd0, int_raise}, 8'h01);
    bus_write(BASE + 8'd0, 8'h00);
    check("dis_held", {7'd0, int_raise}, 8'h01);
    check("dis_held_id", {5'd0, int_id}, 8'h01);
    ack_pulse();
    steps(3);
    check("dis_no_reraise", {7'd0, int_raise}, 8'h00);

    // W1C lands on the same edge as the synchronised rise: set wins
    irq_in = 4'b0010;
    step();
    irq_in = 4'b0000;
    step();
    bus_write(BASE + 8'd2, 8'h02);
    exp_q.push_back(8'h02);
    read_chk("w1c_race_set", BASE + 8'd2);
    bus_write(BASE + 8'd2, 8'h02);
    exp_q.push_back(8'h00);
    read_chk("w1c_clear", BASE + 8'd2);

    // Async reset while raised
    bus_write(BASE + 8'd0, 8'h01);
    irq_in = 4'b0001;
    step();
    irq_in = 4'b0000;
    steps(3);
    check("arst_pre_raise", {7'd0, int_raise}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_raise_drop", {7'd0, int_raise}, 8'h00);
    check("arst_state", {6'd0, fsm_state}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(8'h00);
    read_chk("arst_status", BASE + 8'd3);
    exp_q.push_back(8'h00);
    read_chk("arst_enable", BASE + 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_interrupt_controller.md
Name: bus_interrupt_controller

Overview:
- Memory-mapped, parametrised interrupt controller on the 8-bit processor bus.
- Gathers up to 8 peripheral interrupt sources into one raise/ack interrupt channel toward the processor.
- Per-source enable masks, edge or level mode, fixed priority, and a readable active-source ID.
- Replaces the fixed 2-line raise/ack wiring with a scalable front end.

Parameters:
- NUM_SOURCES, 4, number of interrupt sources. Legal range 1..8.
- BASE_ADDR, 8'hF0, first of 4 consecutive register addresses on BUS_ADDR.

Ports:
- CLK  input  1  system clock; all logic rising-edge.
- RESET  input  1  asynchronous, active-low reset (asserted when 0).
- BUS_DATA  inout  8  shared data bus; tristated when not driving a read.
- BUS_ADDR  input  8  bus address.
- BUS_WE  input  1  1 = write cycle, 0 = read cycle.
- IRQ_IN  input  NUM_SOURCES  asynchronous peripheral interrupt requests.
- INT_RAISE  output  1  interrupt request to the processor.
- INT_ACK  input  1  single-cycle acknowledge from the processor.
- INT_ID  output  3  index of the source being raised.

Behaviour:
- Reset (RESET=0, async):
  - ENABLE=0, MODE=0, PENDING=0.
  - Synchroniser and edge-history flops = 0.
  - INT_RAISE=0, INT_ID=0, BUS_DATA=Z, FSM=IDLE.
- Register map (reads of bits above NUM_SOURCES-1 return 0):
  - BASE+0 ENABLE: RW.
  - BASE+1 MODE: RW. 1 = level, 0 = rising edge.
  - BASE+2 PENDING: read; write-1-to-clear. Clear affects edge-mode bits only.
  - BASE+3 STATUS: read-only, {INT_RAISE, 4'b0, INT_ID}. Writes ignored.
- Bus write: when BUS_WE=1 and the address matches, the register updates on that CLK edge.
- Bus read: when BUS_WE=0 and the address matches on edge k, the output-enable and read-data registers load on edge k. BUS_DATA is driven from edge k until the first edge where the address no longer matches or BUS_WE=1; otherwise Z.
- Input sync: each IRQ_IN bit passes through a 2-flop synchroniser (sync). The sync-to-PENDING path adds one more cycle, so an IRQ_IN change is reflected in PENDING 3 edges later.
- Edge mode (MODE[i]=0): a rising edge of sync[i] (sync=1, previous=0) sets PENDING[i]. The bit stays set until a W1C write or an ACK for source i.
  - A set and a clear in the same cycle: set wins.
- Level mode (MODE[i]=1): PENDING[i] = sync[i] every cycle. W1C and ACK have no effect on it.
- Eligible set: PENDING & ENABLE. Priority is fixed: the lowest index wins.
- FSM:
  - IDLE: if the eligible set is non-empty, latch INT_ID = winner and set INT_RAISE=1 on the same edge -> RAISED.
  - RAISED: hold INT_RAISE=1 and INT_ID stable. Changes to ENABLE/MODE/PENDING do not retract the request.
    - On INT_ACK=1: INT_RAISE=0 and, if MODE[INT_ID]=0, clear PENDING[INT_ID] -> GAP.
  - GAP: one cycle with INT_RAISE=0. Gives the processor a guaranteed low between requests -> IDLE. Re-arbitration happens in IDLE.
- Latency: edge-mode IRQ_IN rising (with ENABLE set, FSM in IDLE) -> INT_RAISE high at the 4th CLK edge.
- INT_ACK while in IDLE or GAP: ignored.
- A level source still high after ACK re-raises: ACK edge -> GAP -> IDLE -> RAISED, so INT_RAISE goes high again 2 edges after the ACK edge.
- Writing ENABLE to 0 while in RAISED: the current request completes normally; the source is not re-raised afterwards.
- RESET asserted mid-operation: all state returns to reset values immediately; BUS_DATA goes Z asynchronously.
- NUM_SOURCES=1: INT_ID is always 0; priority logic degenerates to a single compare.

Test Plan:
- Reset: RESET=0 with IRQ_IN=all 1s -> INT_RAISE=0, BUS_DATA=Z. After release, reading BASE+0..3 returns 8'h00 each.
- Edge priority:
  - Write ENABLE=8'h0F, MODE=0, then pulse IRQ_IN[2] and IRQ_IN[1] in the same cycle.
  - INT_RAISE rises on the 4th edge with INT_ID=1.
  - Pulse INT_ACK -> one GAP cycle, then INT_ID=2, INT_RAISE=1. PENDING reads 8'h04 before the second ACK and 8'h00 after it.
- Level re-raise: MODE=8'h01, ENABLE=8'h01, hold IRQ_IN[0]=1. ACK -> INT_RAISE low for exactly 2 cycles, then high with INT_ID=0. Writing PENDING=8'h01 leaves PENDING=8'h01.
- Mask: ENABLE=0, edge on IRQ_IN[3] -> PENDING=8'h08, INT_RAISE stays 0. Write ENABLE=8'h08 -> INT_RAISE=1 next edge, INT_ID=3.
- W1C race: a W1C write to bit 1 on the same edge IRQ_IN[1]'s synchronised edge lands -> PENDING[1]=1.
- Async reset in RAISED: assert RESET between edges -> INT_RAISE drops without a clock edge. After release, STATUS reads 8'h00.
